// File: rtl/player_move_controller.sv
// Player position controller: samples direction keys on a game tick, drives a step request to the
// combinational collision detector, and commits or rejects the returned position.
module player_move_controller #(
  parameter int POS_W    = 4,
  parameter int MAX_X    = 14,
  parameter int MAX_Y    = 14,
  parameter int START_X  = 1,
  parameter int START_Y  = 1,
  parameter int TICK_DIV = 5000000,
  parameter int REPEAT   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_right,
  input  logic             key_up,
  input  logic             key_left,
  input  logic             key_down,
  input  logic             respawn,
  input  logic [POS_W-1:0] new_x,
  input  logic [POS_W-1:0] new_y,
  output logic [POS_W-1:0] cur_x,
  output logic [POS_W-1:0] cur_y,
  output logic [1:0]       move,
  output logic             busy,
  output logic             moved,
  output logic             blocked
);

  localparam int               CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] START_X_L = POS_W'(START_X);
  localparam logic [POS_W-1:0] START_Y_L = POS_W'(START_Y);
  localparam logic [POS_W-1:0] MAX_X_L   = POS_W'(MAX_X);
  localparam logic [POS_W-1:0] MAX_Y_L   = POS_W'(MAX_Y);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, WAIT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         key_p0, key_p1;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [1:0]         move_nxt;
  logic [POS_W-1:0]   cur_x_nxt, cur_y_nxt;
  logic               moved_nxt, blocked_nxt;

  // Key vector order {down, left, up, right}; lowest set bit wins.
  function automatic logic [1:0] prio_code(input logic [3:0] k);
    if (k[0])      return 2'b00;
    else if (k[1]) return 2'b01;
    else if (k[2]) return 2'b10;
    else           return 2'b11;
  endfunction

  function automatic logic in_range(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
    return (x <= MAX_X_L) && (y <= MAX_Y_L);
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous keys
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_p0 <= '0;
      key_p1 <= '0;
    end else begin
      key_p0 <= {key_down, key_left, key_up, key_right};
      key_p1 <= key_p0;
    end
  end

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt   = state;
    move_nxt    = move;
    cur_x_nxt   = cur_x;
    cur_y_nxt   = cur_y;
    moved_nxt   = 1'b0;
    blocked_nxt = 1'b0;
    if (respawn) begin
      state_nxt = IDLE;
      cur_x_nxt = START_X_L;
      cur_y_nxt = START_Y_L;
    end else begin
      case (state)
        IDLE: begin
          if (tick && (|key_p1)) begin
            move_nxt  = prio_code(key_p1);
            state_nxt = ISSUE;
          end
        end
        ISSUE: state_nxt = COMMIT;
        COMMIT: begin
          // A result equal to the current cell means the detector hit a wall.
          if (!in_range(new_x, new_y) || ((new_x == cur_x) && (new_y == cur_y))) begin
            blocked_nxt = 1'b1;
          end else begin
            cur_x_nxt = new_x;
            cur_y_nxt = new_y;
            moved_nxt = 1'b1;
          end
          state_nxt = (REPEAT != 0) ? IDLE : WAIT;
        end
        WAIT: begin
          if (!(|key_p1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      move    <= 2'b00;
      cur_x   <= START_X_L;
      cur_y   <= START_Y_L;
      moved   <= 1'b0;
      blocked <= 1'b0;
    end else begin
      state   <= state_nxt;
      move    <= move_nxt;
      cur_x   <= cur_x_nxt;
      cur_y   <= cur_y_nxt;
      moved   <= moved_nxt;
      blocked <= blocked_nxt;
    end
  end

  assign busy = (state == ISSUE) || (state == COMMIT);

endmodule

// File: tb/tb_player_move_controller.sv
// Bench for player_move_controller: two instances (key repeat on and off) with a modelled
// collision detector; step results are queued at stimulus time and popped on moved/blocked pulses.
module tb_player_move_controller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] k0 = '0, k1 = '0;
  logic       respawn0 = 1'b0, respawn1 = 1'b0;
  logic       wrap0 = 1'b0, wrap1 = 1'b0;
  logic [3:0] nx0, ny0, nx1, ny1, cur_x0, cur_y0, cur_x1, cur_y1;
  logic [1:0] move0, move1;
  logic       busy0, moved0, blocked0, busy1, moved1, blocked1;
  logic [1:0] c;
  int         n_checks = 0;
  int         n_err = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  // Detector: walls along x=0 and y=0; RIGHT x+1, UP y-1, LEFT x-1, DOWN y+1.
  function automatic logic [7:0] det(input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [1:0] mv, input logic wrap);
    logic [3:0] x, y;
    x = cx;
    y = cy;
    case (mv)
      2'b00:   x = cx + 4'd1;
      2'b01:   y = cy - 4'd1;
      2'b10:   x = cx - 4'd1;
      default: y = cy + 4'd1;
    endcase
    if (x == 4'd0 || y == 4'd0) begin
      x = cx;
      y = cy;
    end
    if (wrap) x = 4'hF;
    return {x, y};
  endfunction

  assign {nx0, ny0} = det(cur_x0, cur_y0, move0, wrap0);
  assign {nx1, ny1} = det(cur_x1, cur_y1, move1, wrap1);

  player_move_controller #(.TICK_DIV(4), .REPEAT(1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .key_right(k0[0]), .key_up(k0[1]), .key_left(k0[2]), .key_down(k0[3]),
    .respawn(respawn0), .new_x(nx0), .new_y(ny0),
    .cur_x(cur_x0), .cur_y(cur_y0), .move(move0),
    .busy(busy0), .moved(moved0), .blocked(blocked0)
  );

  player_move_controller #(.TICK_DIV(4), .REPEAT(0)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .key_right(k1[0]), .key_up(k1[1]), .key_left(k1[2]), .key_down(k1[3]),
    .respawn(respawn1), .new_x(nx1), .new_y(ny1),
    .cur_x(cur_x1), .cur_y(cur_y1), .move(move1),
    .busy(busy1), .moved(moved1), .blocked(blocked1)
  );

  // Reference tick phase: c==3 marks the tick cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) c <= 2'd0;
    else         c <= c + 2'd1;
  end

  function automatic logic [9:0] exp_m(input logic [3:0] x, input logic [3:0] y);
    return {2'b10, x, y};
  endfunction

  function automatic logic [9:0] exp_b(input logic [3:0] x, input logic [3:0] y);
    return {2'b01, x, y};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(negedge clk); while (c != 2'd3);
  endtask

  task automatic hold(input int which, input logic [3:0] k, input int n);
    wait_tick();
    if (which == 0) k0 = k; else k1 = k;
    repeat (n) wait_tick();
    if (which == 0) k0 = '0; else k1 = '0;
  endtask

  initial forever begin
    @(negedge clk);
    if (moved0 || blocked0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut0_unexpected_pulse: got moved=%0b blocked=%0b cur=(%0d,%0d) expected none",
                 moved0, blocked0, cur_x0, cur_y0);
      end else begin
        chk("dut0_step", 16'({moved0, blocked0, cur_x0, cur_y0}), 16'(q0.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (moved1 || blocked1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut1_unexpected_pulse: got moved=%0b blocked=%0b cur=(%0d,%0d) expected none",
                 moved1, blocked1, cur_x1, cur_y1);
      end else begin
        chk("dut1_step", 16'({moved1, blocked1, cur_x1, cur_y1}), 16'(q1.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cur_x", 16'(cur_x0), 16'd1);
    chk("reset_cur_y", 16'(cur_y0), 16'd1);
    chk("reset_move", 16'(move0), 16'd0);
    chk("reset_pulses_busy", 16'({busy0, moved0, blocked0}), 16'd0);
    chk("reset_dut1_cur", 16'({cur_x1, cur_y1}), 16'h11);
    resetn = 1'b1;

    // Reset dropped during COMMIT of a right step
    wait_tick();
    k0 = 4'b0001;
    wait_tick();
    @(negedge clk);
    chk("t1_issue_busy", 16'(busy0), 16'd1);
    @(negedge clk);
    chk("t1_commit_newx", 16'(nx0), 16'd2);
    resetn = 1'b0;
    #1;
    chk("t1_cur_after_reset", 16'({cur_x0, cur_y0}), 16'h11);
    chk("t1_pulses_busy", 16'({busy0, moved0, blocked0}), 16'd0);
    k0 = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t1_cur_held", 16'({cur_x0, cur_y0}), 16'h11);

    // Left into the x=0 wall
    q0.push_back(exp_b(4'd1, 4'd1));
    hold(0, 4'b0100, 1);
    // Right held for three ticks
    q0.push_back(exp_m(4'd2, 4'd1));
    q0.push_back(exp_m(4'd3, 4'd1));
    q0.push_back(exp_m(4'd4, 4'd1));
    hold(0, 4'b0001, 3);
    q0.push_back(exp_m(4'd4, 4'd2));
    hold(0, 4'b1000, 1);
    wait_tick();
    wait_tick();
    chk("t2_cur", 16'({cur_x0, cur_y0}), 16'h42);

    // Up+left+down together: UP wins; keys released during ISSUE
    wait_tick();
    q0.push_back(exp_m(4'd4, 4'd1));
    k0 = 4'b1110;
    wait_tick();
    @(negedge clk);
    chk("t4_move_up", 16'(move0), 16'd1);
    chk("t4_busy", 16'(busy0), 16'd1);
    k0 = '0;
    wait_tick();
    wait_tick();
    chk("t4_cur", 16'({cur_x0, cur_y0}), 16'h41);

    // Detector returns x=15
    wrap0 = 1'b1;
    q0.push_back(exp_b(4'd4, 4'd1));
    hold(0, 4'b0001, 1);
    wait_tick();
    wrap0 = 1'b0;
    chk("t5_cur", 16'({cur_x0, cur_y0}), 16'h41);

    // Walk to (5,3), then respawn during ISSUE
    q0.push_back(exp_m(4'd5, 4'd1));
    hold(0, 4'b0001, 1);
    q0.push_back(exp_m(4'd5, 4'd2));
    q0.push_back(exp_m(4'd5, 4'd3));
    hold(0, 4'b1000, 2);
    wait_tick();
    chk("t6_cur_before", 16'({cur_x0, cur_y0}), 16'h53);
    k0 = 4'b0001;
    wait_tick();
    @(negedge clk);
    chk("t6_issue_busy", 16'(busy0), 16'd1);
    respawn0 = 1'b1;
    k0 = '0;
    @(negedge clk);
    respawn0 = 1'b0;
    chk("t6_cur_respawn", 16'({cur_x0, cur_y0}), 16'h11);
    chk("t6_busy", 16'(busy0), 16'd0);
    wait_tick();
    wait_tick();
    chk("t6_cur_held", 16'({cur_x0, cur_y0}), 16'h11);

    // Single-step mode: a held key gives one step until released
    q1.push_back(exp_m(4'd2, 4'd1));
    wait_tick();
    k1 = 4'b0001;
    wait_tick();
    wait_tick();
    chk("t7_wait_not_busy", 16'(busy1), 16'd0);
    wait_tick();
    k1 = '0;
    wait_tick();
    q1.push_back(exp_m(4'd3, 4'd1));
    hold(1, 4'b0001, 1);
    wait_tick();
    chk("t7_cur", 16'({cur_x1, cur_y1}), 16'h31);

    repeat (10) @(negedge clk);
    chk("q0_drained", 16'(q0.size()), 16'd0);
    chk("q1_drained", 16'(q1.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
